vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 73 +++++++
 1 files changed

// File: rtl/vga_timing.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync and blanking flags, all cycle-aligned with the counts they describe.
module vga_timing #(
  parameter int unsigned HOR_PIXELS = 800,
  parameter int unsigned HOR_FRONT  = 40,
  parameter int unsigned HOR_SYNC   = 128,
  parameter int unsigned HOR_BACK   = 88,
  parameter int unsigned VER_PIXELS = 600,
  parameter int unsigned VER_FRONT  = 1,
  parameter int unsigned VER_SYNC   = 4,
  parameter int unsigned VER_BACK   = 23
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int unsigned HTOTAL = HOR_PIXELS + HOR_FRONT + HOR_SYNC + HOR_BACK;
  localparam int unsigned VTOTAL = VER_PIXELS + VER_FRONT + VER_SYNC + VER_BACK;

  localparam logic [10:0] H_LAST     = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(VTOTAL - 1);
  localparam logic [10:0] H_BLNK     = 11'(HOR_PIXELS);
  localparam logic [10:0] H_SYNC_BEG = 11'(HOR_PIXELS + HOR_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(HOR_PIXELS + HOR_FRONT + HOR_SYNC);
  localparam logic [10:0] V_BLNK     = 11'(VER_PIXELS);
  localparam logic [10:0] V_SYNC_BEG = 11'(VER_PIXELS + VER_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(VER_PIXELS + VER_FRONT + VER_SYNC);

  logic [10:0] h_next;
  logic [10:0] v_next;

  always_comb begin
    h_next = hcount + 11'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + 11'd1;
    end
  end

  // Flags are decoded from the next counts so they land in the same cycle
  // as the counter values they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next >= H_BLNK);
      hsync       <= (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
      vblnk       <= (v_next >= V_BLNK);
      vsync       <= (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
      rgb         <= '0;
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

endmodule
